// File: rtl/sigma_power_iter_pkg.sv
// ============================================================================
// sigma_power_iter_pkg : shared state encoding for the sigma power-iteration engine
// Rev 1.0
// ============================================================================
`default_nettype none

package sigma_power_iter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_DIV   = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sigma_power_iter_if.sv
// ============================================================================
// sigma_power_iter_if : matrix stream in, sigma result out
// Rev 1.0
// ============================================================================
`default_nettype none

interface sigma_power_iter_if #(
    parameter int PRECISION = 32,
    parameter int ITW       = 7
);
    logic                 tvalid;
    logic                 tready;
    logic [PRECISION-1:0] tdata;
    logic                 tlast;
    logic [PRECISION-1:0] err;
    logic                 valid;
    logic [PRECISION-1:0] sigma;
    logic [ITW-1:0]       iters;
    logic                 timeout;
    logic                 fmt_err;

    modport master (
        output tvalid, tdata, tlast, err,
        input  tready, valid, sigma, iters, timeout, fmt_err
    );

    modport slave (
        input  tvalid, tdata, tlast, err,
        output tready, valid, sigma, iters, timeout, fmt_err
    );
endinterface

`default_nettype wire

// File: rtl/sigma_power_iter_fx_div_serial.sv
// ============================================================================
// sigma_power_iter_fx_div_serial : restoring sign-magnitude divider, (num<<FRAC)/den,
// one quotient bit per cycle, PRECISION+FRAC cycles from start to done.
// Rev 1.0
// ============================================================================
`default_nettype none

module sigma_power_iter_fx_div_serial #(
    parameter int PRECISION = 32,
    parameter int FRAC      = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [PRECISION-1:0]        num_mag,
    input  logic                        num_neg,
    input  logic [PRECISION-1:0]        den,
    output logic                        busy,
    output logic                        done,
    output logic signed [PRECISION-1:0] quot
);
    localparam int QW = PRECISION + FRAC;
    localparam int CW = $clog2(QW + 1);
    localparam logic [QW-1:0] ONE_Q = QW'(1) << FRAC;

    logic [PRECISION-1:0] rem, den_r, src_rem, src_den, rem_next, mag;
    logic [QW-1:0]        dvd, quo, src_dvd, src_quo, quo_next, dvd_next;
    logic [PRECISION:0]   trial;
    logic                 neg;
    logic [CW-1:0]        cnt;

    // The start cycle already retires the first quotient bit from the fresh operands.
    always_comb begin
        src_rem  = start ? '0 : rem;
        src_den  = start ? den : den_r;
        src_dvd  = start ? {num_mag, {FRAC{1'b0}}} : dvd;
        src_quo  = start ? '0 : quo;
        trial    = {src_rem, src_dvd[QW-1]};
        dvd_next = src_dvd << 1;
        if (trial >= {1'b0, src_den}) begin
            rem_next = trial[PRECISION-1:0] - src_den;
            quo_next = {src_quo[QW-2:0], 1'b1};
        end else begin
            rem_next = trial[PRECISION-1:0];
            quo_next = {src_quo[QW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem   <= '0;
            den_r <= '0;
            dvd   <= '0;
            quo   <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy  <= 1'b1;
                cnt   <= CW'(QW - 1);
                rem   <= rem_next;
                dvd   <= dvd_next;
                quo   <= quo_next;
                den_r <= den;
                neg   <= num_neg;
            end else if (busy) begin
                rem <= rem_next;
                dvd <= dvd_next;
                quo <= quo_next;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // A saturated most-negative y can exceed lambda by one LSB; keep |x| within ONE.
    always_comb begin
        mag  = (quo > ONE_Q) ? ONE_Q[PRECISION-1:0] : quo[PRECISION-1:0];
        quot = neg ? -$signed(mag) : $signed(mag);
    end

endmodule

`default_nettype wire

// File: rtl/sigma_power_iter.sv
// ============================================================================
// sigma_power_iter : dominant |eigenvalue| of an NxN fixed-point matrix by power
// iteration with infinity-norm normalisation.
// Rev 1.0
// ============================================================================
`default_nettype none

module sigma_power_iter
    import sigma_power_iter_pkg::*;
#(
    parameter int N         = 3,
    parameter int PRECISION = 32,
    parameter int FRAC      = 16,
    parameter int MAX_ITER  = 64,
    parameter int ITW       = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    sigma_power_iter_if.slave bus
);
    localparam int NN   = N * N;
    localparam int IW   = $clog2(N);
    localparam int KW   = $clog2(NN);
    localparam int ACCW = 2 * PRECISION + $clog2(N);
    localparam logic signed [PRECISION-1:0] ONE    = PRECISION'(1) << FRAC;
    localparam logic signed [PRECISION-1:0] MAXP   = {1'b0, {(PRECISION-1){1'b1}}};
    localparam logic signed [PRECISION-1:0] MINP   = {1'b1, {(PRECISION-1){1'b0}}};
    localparam logic signed [ACCW-1:0]      SAT_HI = ACCW'(MAXP);
    localparam logic signed [ACCW-1:0]      SAT_LO = ACCW'(MINP);

    state_t state, state_next;

    logic signed [PRECISION-1:0]   a_mat [NN];
    logic signed [PRECISION-1:0]   x_vec [N];
    logic signed [PRECISION-1:0]   y_vec [N];
    logic [KW-1:0]                 beat, mac_idx;
    logic [IW-1:0]                 row, col, div_idx, div_sel;
    logic signed [ACCW-1:0]        acc, acc_sum, acc_shift;
    logic signed [2*PRECISION-1:0] prod;
    logic signed [PRECISION-1:0]   y_new, div_y, div_quot;
    logic [PRECISION-1:0]          y_abs, lam_new, lam_diff, div_mag;
    logic [PRECISION-1:0]          lambda, lambda_prev, err_q;
    logic [ITW-1:0]                iter_cnt;
    logic                          timeout_int;
    logic                          accept, load_end, bad_last, row_end, mac_last;
    logic                          converged, iter_cap, div_start, div_busy, div_done;

    assign bus.tready = reset_n && (state == ST_IDLE || state == ST_LOAD);
    assign accept     = bus.tvalid && bus.tready;
    assign load_end   = (beat == KW'(NN - 1));
    assign bad_last   = (bus.tlast != load_end);

    assign prod      = a_mat[mac_idx] * x_vec[col];
    assign acc_sum   = acc + ACCW'(prod);
    assign acc_shift = acc_sum >>> FRAC;
    assign row_end   = (col == IW'(N - 1));
    assign mac_last  = row_end && (row == IW'(N - 1));

    always_comb begin
        if (acc_shift > SAT_HI)      y_new = MAXP;
        else if (acc_shift < SAT_LO) y_new = MINP;
        else                         y_new = acc_shift[PRECISION-1:0];
        if (y_new == MINP)           y_abs = MAXP;
        else if (y_new[PRECISION-1]) y_abs = -y_new;
        else                         y_abs = y_new;
        lam_new = (row_end && (y_abs > lambda)) ? y_abs : lambda;
    end

    assign lam_diff  = (lambda >= lambda_prev) ? (lambda - lambda_prev) : (lambda_prev - lambda);
    assign converged = (lam_diff < err_q);
    assign iter_cap  = (iter_cnt == ITW'(MAX_ITER));

    // Next element is launched in the same cycle the previous quotient is captured.
    assign div_start = (state == ST_DIV) &&
                       ((!div_busy && !div_done) || (div_done && div_idx != IW'(N - 1)));
    assign div_sel   = (div_done && div_idx != IW'(N - 1)) ? div_idx + IW'(1) : div_idx;
    assign div_y     = y_vec[div_sel];
    assign div_mag   = div_y[PRECISION-1] ? -div_y : div_y;

    sigma_power_iter_fx_div_serial #(
        .PRECISION (PRECISION),
        .FRAC      (FRAC)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (div_start),
        .num_mag (div_mag),
        .num_neg (div_y[PRECISION-1]),
        .den     (lambda),
        .busy    (div_busy),
        .done    (div_done),
        .quot    (div_quot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    if (bad_last)      state_next = ST_IDLE;
                    else if (load_end) state_next = ST_MAC;
                    else               state_next = ST_LOAD;
                end
            end
            ST_MAC: begin
                if (mac_last) state_next = (lam_new == '0) ? ST_DONE : ST_DIV;
            end
            ST_DIV: begin
                if (div_done && div_idx == IW'(N - 1)) state_next = ST_CHECK;
            end
            ST_CHECK: state_next = (converged || iter_cap) ? ST_DONE : ST_MAC;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NN; i++) a_mat[i] <= '0;
            for (int i = 0; i < N; i++) begin
                x_vec[i] <= '0;
                y_vec[i] <= '0;
            end
            beat        <= '0;
            mac_idx     <= '0;
            row         <= '0;
            col         <= '0;
            div_idx     <= '0;
            acc         <= '0;
            lambda      <= '0;
            lambda_prev <= '0;
            err_q       <= '0;
            iter_cnt    <= '0;
            timeout_int <= 1'b0;
            bus.valid   <= 1'b0;
            bus.sigma   <= '0;
            bus.iters   <= '0;
            bus.timeout <= 1'b0;
            bus.fmt_err <= 1'b0;
        end else begin
            bus.valid   <= 1'b0;
            bus.fmt_err <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        a_mat[beat] <= bus.tdata;
                        if (beat == '0) err_q <= bus.err;
                        if (bad_last) begin
                            bus.fmt_err <= 1'b1;
                            beat        <= '0;
                        end else if (load_end) begin
                            beat <= '0;
                            for (int i = 0; i < N; i++) x_vec[i] <= ONE;
                            lambda      <= '0;
                            lambda_prev <= '0;
                            iter_cnt    <= '0;
                            timeout_int <= 1'b0;
                            acc         <= '0;
                            row         <= '0;
                            col         <= '0;
                            mac_idx     <= '0;
                            div_idx     <= '0;
                        end else begin
                            beat <= beat + KW'(1);
                        end
                    end
                end
                ST_MAC: begin
                    acc     <= row_end ? '0 : acc_sum;
                    lambda  <= lam_new;
                    mac_idx <= mac_idx + KW'(1);
                    if (row_end) begin
                        y_vec[row] <= y_new;
                        col        <= '0;
                        row        <= row + IW'(1);
                    end else begin
                        col <= col + IW'(1);
                    end
                    if (mac_last) begin
                        row         <= '0;
                        mac_idx     <= '0;
                        iter_cnt    <= iter_cnt + ITW'(1);
                        timeout_int <= 1'b0;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        x_vec[div_idx] <= div_quot;
                        div_idx        <= (div_idx == IW'(N - 1)) ? '0 : div_idx + IW'(1);
                    end
                end
                ST_CHECK: begin
                    timeout_int <= !converged && iter_cap;
                    if (!converged && !iter_cap) begin
                        lambda_prev <= lambda;
                        lambda      <= '0;
                    end
                end
                ST_DONE: begin
                    bus.valid   <= 1'b1;
                    bus.sigma   <= lambda;
                    bus.iters   <= iter_cnt;
                    bus.timeout <= timeout_int;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sigma_power_iter.sv
// ============================================================================
// tb_sigma_power_iter : directed matrices with a scoreboard of expected results
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sigma_power_iter;
    localparam int P   = 32;
    localparam int ITW = 7;
    localparam logic [P-1:0] O   = 32'h0001_0000;
    localparam logic [P-1:0] T   = 32'h0002_0000;
    localparam logic [P-1:0] ERR = 32'h0000_1999;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sigma_power_iter_if #(.PRECISION(P), .ITW(ITW)) bus ();

    sigma_power_iter #(
        .N(3), .PRECISION(P), .FRAC(16), .MAX_ITER(64)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit           is_fmt;
        logic [P-1:0] sigma;
        logic [ITW-1:0] iters;
        logic         timeout;
        int           lat;
    } exp_t;

    typedef logic [P-1:0] mat_t [9];

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per valid or fmt_err pulse.
    always @(negedge clk) begin
        if (reset_n && (bus.valid || bus.fmt_err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual valid=%0b fmt_err=%0b required none",
                         bus.valid, bus.fmt_err);
            end else begin
                e = sb.pop_front();
                chk("fmt_kind", 64'(bus.fmt_err), 64'(e.is_fmt));
                if (e.is_fmt) begin
                    chk("fmt_valid", 64'(bus.valid), 64'd0);
                    chk("fmt_tready", 64'(bus.tready), 64'd1);
                end else begin
                    chk("sigma", 64'(bus.sigma), 64'(e.sigma));
                    chk("iters", 64'(bus.iters), 64'(e.iters));
                    chk("timeout", 64'(bus.timeout), 64'(e.timeout));
                    chk("latency", 64'(cyc - last_acc), 64'(e.lat));
                end
            end
        end
    end

    task automatic push_res(input logic [P-1:0] s, input int it, input logic to, input int lat);
        exp_t x;
        x.is_fmt = 1'b0; x.sigma = s; x.iters = ITW'(it); x.timeout = to; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic push_fmt();
        exp_t x;
        x.is_fmt = 1'b1; x.sigma = '0; x.iters = '0; x.timeout = 1'b0; x.lat = 0;
        sb.push_back(x);
    endtask

    // Called and returns at posedge+1.
    task automatic send_beat(input logic [P-1:0] d, input logic l);
        int g = 0;
        bus.tvalid = 1'b1;
        bus.tdata  = d;
        bus.tlast  = l;
        while (!bus.tready && g < 1000) begin
            @(posedge clk); #1;
            g++;
        end
        if (!bus.tready) begin
            checks++;
            errors++;
            $display("FAIL tready_wait actual=0 required=1");
        end
        @(posedge clk); #1;
        last_acc = cyc;
    endtask

    task automatic send_matrix(input mat_t m, input int tlast_pos, input int nbeats,
                               input logic [P-1:0] err_v);
        bus.err = err_v;
        for (int k = 0; k < nbeats; k++) send_beat(m[k], (k == tlast_pos));
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 20000) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t d2, z, perm, d1;
        d2   = '{T, 0, 0, 0, T, 0, 0, 0, T};
        z    = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        perm = '{0, O, 0, 0, 0, O, O, 0, 0};
        d1   = '{O, 0, 0, 0, O, 0, 0, 0, O};
        bus.tvalid = 1'b0;
        bus.tdata  = '0;
        bus.tlast  = 1'b0;
        bus.err    = ERR;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_sigma", 64'(bus.sigma), 64'd0);
        chk("rst_iters", 64'(bus.iters), 64'd0);
        chk("rst_timeout", 64'(bus.timeout), 64'd0);
        chk("rst_fmt_err", 64'(bus.fmt_err), 64'd0);
        chk("rst_tready", 64'(bus.tready), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_tready", 64'(bus.tready), 64'd1);

        // diag(2,2,2)
        push_res(T, 2, 1'b0, 2 * 155 + 1);
        send_matrix(d2, 8, 9, ERR);
        wait_drain();

        // all-zero matrix
        push_res('0, 1, 1'b0, 10);
        send_matrix(z, 8, 9, ERR);
        wait_drain();

        // cyclic permutation
        push_res(O, 2, 1'b0, 2 * 155 + 1);
        send_matrix(perm, 8, 9, ERR);
        wait_drain();

        // identity with err=0 never converges
        push_res(O, 64, 1'b1, 64 * 155 + 1);
        send_matrix(d1, 8, 9, '0);
        wait_drain();

        // tlast on beat 5, then correct reload
        push_fmt();
        send_matrix(d2, 5, 6, ERR);
        @(posedge clk); #1;
        chk("fmt_pulse_width", 64'(bus.fmt_err), 64'd0);
        wait_drain();
        push_res(T, 2, 1'b0, 2 * 155 + 1);
        send_matrix(d2, 8, 9, ERR);
        wait_drain();

        // busy stream ignored, then reset in the middle of DIV
        send_matrix(d2, 8, 9, ERR);
        bus.tvalid = 1'b1;
        bus.tdata  = 32'hDEAD_BEEF;
        chk("busy_tready_a", 64'(bus.tready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_tready_b", 64'(bus.tready), 64'd0);
        bus.tvalid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("held_sigma", 64'(bus.sigma), 64'(T));
        chk("held_iters", 64'(bus.iters), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sigma", 64'(bus.sigma), 64'd0);
        chk("mid_rst_iters", 64'(bus.iters), 64'd0);
        chk("mid_rst_timeout", 64'(bus.timeout), 64'd0);
        chk("mid_rst_valid", 64'(bus.valid), 64'd0);
        chk("mid_rst_tready", 64'(bus.tready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_tready", 64'(bus.tready), 64'd1);
        repeat (400) @(posedge clk);
        #1;

        // recovery after reset
        push_res(O, 2, 1'b0, 2 * 155 + 1);
        send_matrix(perm, 8, 9, ERR);
        wait_drain();
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
